picosoc_busarb: RTL and testbench

PICOSOC_BUSARB -- requirements
Module: picosoc_busarb

---
 rtl/picosoc_pkg.sv | 20 ++
 rtl/picosoc_rr_arb.sv | 11 +
 rtl/picosoc_busarb.sv | 144 ++++++++++++++
 tb/tb_picosoc_busarb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/picosoc_pkg.sv
// Shared definitions for the PicoSoC two-master bus arbiter.
package picosoc_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } state_e;

    // Read data handed back to a master whose slave access was forced to complete.
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // After reset master 1 counts as last served, so master 0 wins the first tie.
    localparam logic LAST_GRANT_RESET = 1'b1;

    localparam logic [15:0] WAIT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/picosoc_rr_arb.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// master that was not served last.
module picosoc_rr_arb (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    assign gnt = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/picosoc_busarb.sv
// Arbiter that lets a CPU (master 0) and a DMA engine (master 1) share one
// PicoRV32-style valid/ready slave, with an optional slave-wait timeout.
module picosoc_busarb
    import picosoc_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,

    output logic        timeout_irq
);

    localparam logic        TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic        rr_gnt;
    logic        g_valid;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [3:0]  g_wstrb;
    logic        timeout_hit;

    picosoc_rr_arb u_rr_arb (
        .req  ({m1_valid, m0_valid}),
        .last (last_grant_q),
        .gnt  (rr_gnt)
    );

    assign g_valid     = grant_q ? m1_valid : m0_valid;
    assign g_addr      = grant_q ? m1_addr  : m0_addr;
    assign g_wdata     = grant_q ? m1_wdata : m0_wdata;
    assign g_wstrb     = grant_q ? m1_wstrb : m0_wstrb;
    assign timeout_hit = TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LIM);

    // State, grant and wait counter registers; reset drops any grant at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= LAST_GRANT_RESET;
            wait_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // Next-state and output decode; normal completion takes priority over timeout.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        s_valid      = 1'b0;
        s_addr       = 32'd0;
        s_wdata      = 32'd0;
        s_wstrb      = 4'd0;
        m0_ready     = 1'b0;
        m1_ready     = 1'b0;
        m0_rdata     = 32'd0;
        m1_rdata     = 32'd0;
        timeout_irq  = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d    = GRANT;
                    grant_d    = rr_gnt;
                    wait_cnt_d = 16'd0;
                end
            end
            GRANT: begin
                s_addr  = g_addr;
                s_wdata = g_wdata;
                if (!g_valid) begin
                    state_d = IDLE;
                end else if (s_ready) begin
                    s_valid      = 1'b1;
                    s_wstrb      = g_wstrb;
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                    if (grant_q) begin
                        m1_ready = 1'b1;
                        m1_rdata = s_rdata;
                    end else begin
                        m0_ready = 1'b1;
                        m0_rdata = s_rdata;
                    end
                end else if (timeout_hit) begin
                    timeout_irq  = 1'b1;
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                    if (grant_q) begin
                        m1_ready = 1'b1;
                        m1_rdata = ERR_RDATA;
                    end else begin
                        m0_ready = 1'b1;
                        m0_rdata = ERR_RDATA;
                    end
                end else begin
                    s_valid = 1'b1;
                    s_wstrb = g_wstrb;
                    if (wait_cnt_q != WAIT_CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_picosoc_busarb.sv
// Self-checking bench for picosoc_busarb: a transaction-level model of the
// arbiter is compared against every output on each falling clock edge, and
// directed scenarios pin the model with hand-computed values.
module tb_picosoc_busarb;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0, m1_addr = 32'd0, m1_wdata = 32'd0;
    logic [3:0]  m0_wstrb = 4'd0, m1_wstrb = 4'd0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic        s_ready = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata = 32'd0;
    logic        timeout_irq;

    int checks = 0;
    int errors = 0;

    picosoc_busarb #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0_valid    (m0_valid),
        .m0_ready    (m0_ready),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wstrb    (m0_wstrb),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_ready    (m1_ready),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wstrb    (m1_wstrb),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_rdata     (s_rdata),
        .timeout_irq (timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: whether a transaction is open, which master owns it, how many
    // cycles it has waited, and which master was served last.
    bit mBusy = 1'b0;
    int mOwner = 0;
    int mWaited = 0;
    int mLast = 1;

    function automatic bit ownerValid();
        return (mOwner == 1) ? m1_valid : m0_valid;
    endfunction

    // Advance the transaction model at each rising edge.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mBusy   <= 1'b0;
            mOwner  <= 0;
            mWaited <= 0;
            mLast   <= 1;
        end else if (!mBusy) begin
            if (m0_valid || m1_valid) begin
                mBusy   <= 1'b1;
                mWaited <= 0;
                if (m0_valid && m1_valid) mOwner <= 1 - mLast;
                else                      mOwner <= m1_valid ? 1 : 0;
            end
        end else if (!ownerValid()) begin
            mBusy <= 1'b0;
        end else if (s_ready || (TO != 0 && mWaited == TO)) begin
            mBusy <= 1'b0;
            mLast <= mOwner;
        end else if (mWaited < 65535) begin
            mWaited <= mWaited + 1;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        logic        eValid, eIrq, eRdy0, eRdy1, reqv, done, tmo;
        logic [31:0] eAddr, eWdata, eRd0, eRd1, rd;
        logic [3:0]  eStrb;
        eValid = 0; eIrq = 0; eRdy0 = 0; eRdy1 = 0;
        eAddr = 0; eWdata = 0; eRd0 = 0; eRd1 = 0; eStrb = 0;
        if (resetn && mBusy) begin
            reqv   = ownerValid();
            done   = reqv && s_ready;
            tmo    = reqv && !s_ready && (TO != 0) && (mWaited == TO);
            rd     = done ? s_rdata : (tmo ? ERR : 32'd0);
            eValid = reqv && !tmo;
            eAddr  = (mOwner == 1) ? m1_addr  : m0_addr;
            eWdata = (mOwner == 1) ? m1_wdata : m0_wdata;
            eStrb  = eValid ? ((mOwner == 1) ? m1_wstrb : m0_wstrb) : 4'd0;
            eIrq   = tmo;
            if (mOwner == 1) begin eRdy1 = done || tmo; eRd1 = rd; end
            else             begin eRdy0 = done || tmo; eRd0 = rd; end
        end
        checkOutput("s_valid", {31'd0, s_valid}, {31'd0, eValid});
        checkOutput("s_addr", s_addr, eAddr);
        checkOutput("s_wdata", s_wdata, eWdata);
        checkOutput("s_wstrb", {28'd0, s_wstrb}, {28'd0, eStrb});
        checkOutput("m0_ready", {31'd0, m0_ready}, {31'd0, eRdy0});
        checkOutput("m1_ready", {31'd0, m1_ready}, {31'd0, eRdy1});
        checkOutput("m0_rdata", m0_rdata, eRd0);
        checkOutput("m1_rdata", m1_rdata, eRd1);
        checkOutput("timeout_irq", {31'd0, timeout_irq}, {31'd0, eIrq});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic v, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] ws);
        if (m == 0) begin m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = ws; end
        else        begin m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = ws; end
    endtask

    // Wait for a grant, answer after 'delay' further cycles, report who got ready.
    task automatic serveOne(input int delay, input logic [31:0] data,
                            output int who, output logic [31:0] rdSeen);
        int n;
        n = 0;
        while (!s_valid && n < 10) begin
            tick();
            n++;
        end
        checkOutput("grant_seen", {31'd0, s_valid}, 32'd1);
        repeat (delay) tick();
        s_ready = 1'b1;
        s_rdata = data;
        #1;
        who    = m0_ready ? 0 : (m1_ready ? 1 : -1);
        rdSeen = m0_ready ? m0_rdata : m1_rdata;
        tick();
        s_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          who;
        logic [31:0] rd;
        int          order[4];
        int          expOrder[4];
        expOrder = '{0, 1, 0, 1};

        repeat (3) tick();
        checkOutput("reset_s_valid", {31'd0, s_valid}, 32'd0);
        checkOutput("reset_m0_ready", {31'd0, m0_ready}, 32'd0);
        checkOutput("reset_s_wstrb", {28'd0, s_wstrb}, 32'd0);
        resetn = 1'b1;

        // Single CPU read answered two cycles after s_valid.
        applyStimulus(0, 1'b1, 32'h0000_0010, 32'd0, 4'd0);
        #1;
        checkOutput("arb_latency", {31'd0, s_valid}, 32'd0);
        tick();
        checkOutput("read_s_addr", s_addr, 32'h0000_0010);
        serveOne(2, 32'h1234_5678, who, rd);
        checkOutput("read_who", who, 0);
        checkOutput("read_rdata", rd, 32'h1234_5678);
        checkOutput("read_m1_ready", {31'd0, m1_ready}, 32'd0);
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("read_ready_once", {31'd0, m0_ready}, 32'd0);
        tick();

        // Fresh reset, then both masters request continuously.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        applyStimulus(0, 1'b1, 32'h0000_0100, 32'd0, 4'd0);
        applyStimulus(1, 1'b1, 32'h0000_0200, 32'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            serveOne(1, 32'h100 + i, who, rd);
            order[i] = who;
        end
        for (int i = 0; i < 4; i++) checkOutput("rr_order", order[i], expOrder[i]);
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();

        // DMA read with a silent slave: forced completion on the fifth cycle.
        applyStimulus(1, 1'b1, 32'h0000_0300, 32'd0, 4'd0);
        tick();
        repeat (3) tick();
        checkOutput("to_irq_early", {31'd0, timeout_irq}, 32'd0);
        checkOutput("to_valid_early", {31'd0, s_valid}, 32'd1);
        tick();
        checkOutput("to_m1_ready", {31'd0, m1_ready}, 32'd1);
        checkOutput("to_irq", {31'd0, timeout_irq}, 32'd1);
        checkOutput("to_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        checkOutput("to_s_valid", {31'd0, s_valid}, 32'd0);
        tick();
        checkOutput("to_irq_pulse", {31'd0, timeout_irq}, 32'd0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();

        // Slave answers exactly on the timeout cycle: normal completion wins.
        applyStimulus(0, 1'b1, 32'h0000_0400, 32'd0, 4'd0);
        tick();
        repeat (3) tick();
        tick();
        s_ready = 1'b1;
        s_rdata = 32'h5555_AAAA;
        #1;
        checkOutput("race_m0_ready", {31'd0, m0_ready}, 32'd1);
        checkOutput("race_m0_rdata", m0_rdata, 32'h5555_AAAA);
        checkOutput("race_irq", {31'd0, timeout_irq}, 32'd0);
        tick();
        s_ready = 1'b0;
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();

        // DMA partial write: strobes and data pass through until s_ready.
        applyStimulus(1, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0011);
        tick();
        checkOutput("wr_strb_c1", {28'd0, s_wstrb}, 32'h3);
        checkOutput("wr_data_c1", s_wdata, 32'hAABB_CCDD);
        tick();
        checkOutput("wr_strb_c2", {28'd0, s_wstrb}, 32'h3);
        serveOne(0, 32'd0, who, rd);
        checkOutput("wr_who", who, 1);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();

        // Reset mid-grant after m0 was served last: next tie must go to m0.
        applyStimulus(0, 1'b1, 32'h0000_0500, 32'd0, 4'd0);
        serveOne(0, 32'd7, who, rd);
        checkOutput("pre_rst_who", who, 0);
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1, 1'b1, 32'h0000_0600, 32'd0, 4'd0);
        tick();
        checkOutput("pre_rst_valid", {31'd0, s_valid}, 32'd1);
        resetn  = 1'b0;
        s_ready = 1'b1;
        #1;
        checkOutput("rst_s_valid", {31'd0, s_valid}, 32'd0);
        checkOutput("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        checkOutput("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
        tick();
        s_ready = 1'b0;
        resetn  = 1'b1;
        applyStimulus(0, 1'b1, 32'h0000_0700, 32'd0, 4'd0);
        serveOne(0, 32'd9, who, rd);
        checkOutput("post_rst_who", who, 0);
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
